// File: rtl/telemetry_pkg.sv
`default_nettype none
// ============================================================================
// Module      : telemetry_pkg
// Description : Shared constants, state type and header helper for the
//               telemetry sampler. Defines the 7-word packet layout, in which
//               word 0 is a header and words 1..6 are the lo/hi halves of the
//               three counters.
// Revision    : 1.0 - initial release
// ============================================================================
package telemetry_pkg;

    localparam logic [7:0]  HDR_MAGIC = 8'hA5;
    localparam int          PKT_WORDS = 7;
    // The header length field counts the payload words that follow the header.
    localparam logic [15:0] HDR_LEN   = 16'(PKT_WORDS - 1);

    // Word index within a packet.
    localparam logic [2:0] IDX_HDR      = 3'd0;
    localparam logic [2:0] IDX_MCYC_LO  = 3'd1;
    localparam logic [2:0] IDX_MCYC_HI  = 3'd2;
    localparam logic [2:0] IDX_INSTR_LO = 3'd3;
    localparam logic [2:0] IDX_INSTR_HI = 3'd4;
    localparam logic [2:0] IDX_STALL_LO = 3'd5;
    localparam logic [2:0] IDX_STALL_HI = 3'd6;
    localparam logic [2:0] IDX_LAST     = IDX_STALL_HI;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } tsamp_state_e;

    function automatic logic [31:0] header_word(input logic [7:0] seq);
        return {HDR_MAGIC, seq, HDR_LEN};
    endfunction

endpackage
`default_nettype wire

// File: rtl/telemetry_interval_timer.sv
`default_nettype none
// ============================================================================
// Module      : telemetry_interval_timer
// Description : Periodic tick generator. While enabled with a non-zero
//               interval I, it emits a one-cycle tick every I cycles. The
//               first tick comes I cycles after the timer starts running.
// Ports       : clk, rst_n (async, active-low)
//               enable   - timer runs only while high
//               interval - period in cycles, 0 disables ticks
//               tick     - one-cycle pulse at the end of each period
// Revision    : 1.0 - initial release
// ============================================================================
module telemetry_interval_timer #(
    parameter int TIMER_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [TIMER_W-1:0] interval,
    output logic               tick
);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;
    logic               run;

    always_comb begin
        cnt_d = '0;
        tick  = 1'b0;
        run   = enable && (interval != '0);
        if (run) begin
            // The >= compare (rather than ==) lets a shrinking interval below
            // the current count fire immediately instead of wrapping around.
            if (cnt_q >= interval - TIMER_W'(1)) begin
                tick  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + TIMER_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/telemetry_sampler.sv
`default_nettype none
// ============================================================================
// Module      : telemetry_sampler
// Description : Snapshots mcycle/minstret/stall_cycles on a timer tick or a
//               software trigger. Each snapshot is serialised as a 7-word
//               32-bit packet on a valid/ready stream. While a packet is in
//               flight, one extra request can be held as pending. Any further
//               request is counted in a saturating dropped counter.
// Ports       : clk, rst_n (async, active-low)
//               enable, interval, sw_trigger     - sampling control
//               mcycle, minstret, stall_cycles   - live counters
//               out_valid/out_ready/out_data/out_last - packet stream
//               busy, dropped, seq                - status
// Revision    : 1.0 - initial release
// ============================================================================
module telemetry_sampler
    import telemetry_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int TIMER_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [TIMER_W-1:0] interval,
    input  logic               sw_trigger,
    input  logic [WIDTH-1:0]   mcycle,
    input  logic [WIDTH-1:0]   minstret,
    input  logic [WIDTH-1:0]   stall_cycles,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_data,
    output logic               out_last,
    output logic               busy,
    output logic [15:0]        dropped,
    output logic [7:0]         seq
);

    tsamp_state_e state_q, state_d;
    logic [2:0]   idx_q, idx_d;
    logic [7:0]   seq_q, seq_d;
    logic         pending_q, pending_d;
    logic [15:0]  dropped_q, dropped_d;
    logic [63:0]  snap_mcycle_q, snap_mcycle_d;
    logic [63:0]  snap_instr_q, snap_instr_d;
    logic [63:0]  snap_stall_q, snap_stall_d;
    logic [31:0]  out_data_q, out_data_d;
    logic         out_last_q, out_last_d;

    logic         tick;
    logic         req;
    logic         handshake;
    logic         final_hs;
    logic         capture;
    logic [2:0]   idx_nxt;
    logic [31:0]  word_nxt;

    telemetry_interval_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .interval (interval),
        .tick     (tick)
    );

    assign req       = enable && (tick || sw_trigger);
    assign handshake = (state_q == EMIT) && out_ready;
    assign final_hs  = handshake && (idx_q == IDX_LAST);

    // The word to present after the current one is accepted. It is taken from
    // the snapshot registers, so it is fully registered at the output.
    always_comb begin
        idx_nxt = idx_q + 3'd1;
        case (idx_nxt)
            IDX_MCYC_LO:  word_nxt = snap_mcycle_q[31:0];
            IDX_MCYC_HI:  word_nxt = snap_mcycle_q[63:32];
            IDX_INSTR_LO: word_nxt = snap_instr_q[31:0];
            IDX_INSTR_HI: word_nxt = snap_instr_q[63:32];
            IDX_STALL_LO: word_nxt = snap_stall_q[31:0];
            IDX_STALL_HI: word_nxt = snap_stall_q[63:32];
            default:      word_nxt = header_word(seq_q);
        endcase
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        seq_d         = seq_q;
        pending_d     = pending_q;
        dropped_d     = dropped_q;
        snap_mcycle_d = snap_mcycle_q;
        snap_instr_d  = snap_instr_q;
        snap_stall_d  = snap_stall_q;
        out_data_d    = out_data_q;
        out_last_d    = out_last_q;
        capture       = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    capture = 1'b1;
                end
            end
            EMIT: begin
                if (final_hs) begin
                    // A waiting or same-cycle request restarts immediately, so
                    // the next header follows the last word without a bubble.
                    if (pending_q || req) begin
                        capture   = 1'b1;
                        pending_d = 1'b0;
                    end else begin
                        state_d    = IDLE;
                        out_data_d = '0;
                        out_last_d = 1'b0;
                    end
                end else begin
                    if (handshake) begin
                        idx_d      = idx_nxt;
                        out_data_d = word_nxt;
                        out_last_d = (idx_nxt == IDX_LAST);
                    end
                    if (req) begin
                        if (!pending_q) begin
                            pending_d = 1'b1;
                        end else if (dropped_q != 16'hFFFF) begin
                            dropped_d = dropped_q + 16'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Counters are sampled when the request is serviced, which for a
        // pending request is later than when it was raised.
        if (capture) begin
            state_d       = EMIT;
            idx_d         = IDX_HDR;
            seq_d         = seq_q + 8'd1;
            snap_mcycle_d = 64'(mcycle);
            snap_instr_d  = 64'(minstret);
            snap_stall_d  = 64'(stall_cycles);
            out_data_d    = header_word(seq_q + 8'd1);
            out_last_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            seq_q         <= '0;
            pending_q     <= 1'b0;
            dropped_q     <= '0;
            snap_mcycle_q <= '0;
            snap_instr_q  <= '0;
            snap_stall_q  <= '0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            seq_q         <= seq_d;
            pending_q     <= pending_d;
            dropped_q     <= dropped_d;
            snap_mcycle_q <= snap_mcycle_d;
            snap_instr_q  <= snap_instr_d;
            snap_stall_q  <= snap_stall_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
        end
    end

    assign out_valid = (state_q == EMIT);
    assign busy      = (state_q == EMIT);
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign dropped   = dropped_q;
    assign seq       = seq_q;

endmodule
`default_nettype wire

// File: tb/tb_telemetry_sampler.sv
`default_nettype none
// ============================================================================
// Module      : tb_telemetry_sampler
// Description : Self-checking bench for telemetry_sampler. A packet-queue
//               reference model predicts the stream, and each cycle's outputs
//               are compared against it. Directed scenarios add literal
//               expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_telemetry_sampler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [31:0] interval;
    logic        sw_trigger;
    logic [63:0] mcycle;
    logic [63:0] minstret;
    logic [63:0] stall_cycles;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic [15:0] dropped;
    logic [7:0]  seq;

    telemetry_sampler #(.WIDTH(64), .TIMER_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .interval     (interval),
        .sw_trigger   (sw_trigger),
        .mcycle       (mcycle),
        .minstret     (minstret),
        .stall_cycles (stall_cycles),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy),
        .dropped      (dropped),
        .seq          (seq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    bit hold_instr = 1'b0;

    // Reference model: the words still to be sent for the current packet.
    logic [31:0] mq[$];
    bit          m_pend;
    logic [31:0] m_cnt;
    logic [7:0]  m_seq;
    logic [15:0] m_drop;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pend = 1'b0;
        m_cnt  = '0;
        m_seq  = '0;
        m_drop = '0;
    endtask

    task automatic push_pkt();
        m_seq = m_seq + 8'd1;
        mq.push_back({8'hA5, m_seq, 16'd6});
        mq.push_back(mcycle[31:0]);
        mq.push_back(mcycle[63:32]);
        mq.push_back(minstret[31:0]);
        mq.push_back(minstret[63:32]);
        mq.push_back(stall_cycles[31:0]);
        mq.push_back(stall_cycles[63:32]);
    endtask

    task automatic note_req();
        if (!m_pend) m_pend = 1'b1;
        else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    endtask

    task automatic model_edge();
        bit tick;
        bit req;
        tick = 1'b0;
        if (enable && interval != 0) begin
            if (m_cnt >= interval - 32'd1) begin
                tick  = 1'b1;
                m_cnt = '0;
            end else begin
                m_cnt = m_cnt + 32'd1;
            end
        end else begin
            m_cnt = '0;
        end
        req = enable && (tick || sw_trigger);
        if (mq.size() != 0) begin
            if (out_ready) begin
                void'(mq.pop_front());
                if (mq.size() == 0) begin
                    if (m_pend || req) begin
                        push_pkt();
                        m_pend = 1'b0;
                    end
                end else if (req) begin
                    note_req();
                end
            end else if (req) begin
                note_req();
            end
        end else if (req) begin
            push_pkt();
        end
    endtask

    task automatic compare();
        bit ev;
        ev = (mq.size() != 0);
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("busy", 64'(busy), 64'(ev));
        chk("seq", 64'(seq), 64'(m_seq));
        chk("dropped", 64'(dropped), 64'(m_drop));
        if (ev) begin
            chk("out_data", 64'(out_data), 64'(mq[0]));
            chk("out_last", 64'(out_last), 64'(mq.size() == 1));
        end
    endtask

    // One clock: model the edge, sample #1 later, then advance the counters.
    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_edge();
        else model_reset();
        #1;
        compare();
        cyc_n++;
        mcycle = mcycle + 64'd1;
        if (!hold_instr) minstret = minstret + 64'($urandom_range(0, 2));
        stall_cycles = stall_cycles + 64'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int n;
        sw_trigger = 1'b0;
        out_ready  = 1'b1;
        n = 0;
        while (mq.size() != 0 && n < 40) begin
            cyc();
            n++;
        end
        chk("drain_idle", 64'(mq.size() == 0), 64'd1);
    endtask

    initial begin
        int          rises[$];
        logic [31:0] hdrs[$];
        logic [31:0] words[7];
        logic [31:0] held;
        logic [7:0]  s_exp;
        bit          prev_v;
        int          n;
        int          lasts;
        int          vcycles;
        int          changes;

        rst_n        = 1'b0;
        enable       = 1'b0;
        interval     = '0;
        sw_trigger   = 1'b0;
        out_ready    = 1'b0;
        mcycle       = {$urandom, $urandom};
        minstret     = {$urandom, $urandom};
        stall_cycles = {$urandom, $urandom};
        model_reset();
        repeat (3) cyc();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_dropped", 64'(dropped), 64'd0);
        chk("rst_seq", 64'(seq), 64'd0);
        rst_n = 1'b1;
        cyc();

        // Periodic sampling every 10 cycles.
        enable    = 1'b1;
        interval  = 32'd10;
        out_ready = 1'b1;
        prev_v    = 1'b0;
        repeat (26) begin
            cyc();
            if (out_valid && !prev_v) begin
                rises.push_back(cyc_n);
                hdrs.push_back(out_data);
            end
            prev_v = out_valid;
        end
        chk("periodic_count", 64'(rises.size() >= 2), 64'd1);
        if (rises.size() >= 2) begin
            chk("periodic_hdr1", 64'(hdrs[0]), 64'h0000_0000_A501_0006);
            chk("periodic_hdr2", 64'(hdrs[1]), 64'h0000_0000_A502_0006);
            chk("periodic_gap", 64'(rises[1] - rises[0]), 64'd10);
        end
        enable = 1'b0;
        drain();

        // Software trigger with a fixed minstret value.
        enable     = 1'b1;
        interval   = '0;
        hold_instr = 1'b1;
        minstret   = 64'h1_0000_0002;
        sw_trigger = 1'b1;
        cyc();
        sw_trigger = 1'b0;
        lasts = 0;
        for (int i = 0; i < 7; i++) begin
            words[i] = out_data;
            if (out_last) lasts++;
            if (i == 6) chk("sw_last_on_w6", 64'(out_last), 64'd1);
            cyc();
        end
        hold_instr = 1'b0;
        chk("sw_word3", 64'(words[3]), 64'h2);
        chk("sw_word4", 64'(words[4]), 64'h1);
        chk("sw_last_count", 64'(lasts), 64'd1);
        drain();

        // Backpressure with three triggers: one pending, two dropped.
        sw_trigger = 1'b1;
        cyc();
        sw_trigger = 1'b0;
        cyc();
        cyc();
        out_ready = 1'b0;
        held      = out_data;
        changes   = 0;
        for (int i = 0; i < 20; i++) begin
            sw_trigger = (i == 3 || i == 8 || i == 13);
            cyc();
            if (out_data != held) changes++;
        end
        sw_trigger = 1'b0;
        chk("stall_stable", 64'(changes), 64'd0);
        chk("stall_dropped", 64'(dropped), 64'd2);
        out_ready = 1'b1;
        lasts   = 0;
        vcycles = 0;
        n       = 0;
        while (out_valid && n < 40) begin
            if (out_last) lasts++;
            vcycles++;
            cyc();
            n++;
        end
        chk("stall_packets", 64'(lasts), 64'd2);
        chk("stall_b2b_words", 64'(vcycles), 64'd12);

        // Trigger coinciding with the final handshake.
        sw_trigger = 1'b1;
        cyc();
        sw_trigger = 1'b0;
        n = 0;
        while (!(out_valid && out_last) && n < 20) begin
            cyc();
            n++;
        end
        chk("final_reached", 64'(out_valid && out_last), 64'd1);
        s_exp      = m_seq + 8'd1;
        sw_trigger = 1'b1;
        cyc();
        sw_trigger = 1'b0;
        chk("b2b_valid", 64'(out_valid), 64'd1);
        chk("b2b_hdr", 64'(out_data), 64'({8'hA5, s_exp, 16'd6}));
        chk("b2b_seq", 64'(seq), 64'(s_exp));
        drain();

        // Continuous triggering until seq wraps past 255.
        sw_trigger = 1'b1;
        out_ready  = 1'b1;
        n = 0;
        while (m_seq != 8'h00 && n < 2200) begin
            cyc();
            n++;
        end
        chk("seq_wrap", 64'(seq), 64'h0);

        // Hold ready low while triggering to saturate the dropped counter.
        out_ready = 1'b0;
        n = 0;
        while (m_drop != 16'hFFFF && n < 70000) begin
            cyc();
            n++;
        end
        repeat (4) cyc();
        chk("dropped_sat", 64'(dropped), 64'hFFFF);
        drain();

        // Asynchronous reset during word 3.
        sw_trigger = 1'b1;
        cyc();
        sw_trigger = 1'b0;
        n = 0;
        while (mq.size() != 4 && n < 10) begin
            cyc();
            n++;
        end
        chk("reset_at_w3", 64'(mq.size()), 64'd4);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_data", 64'(out_data), 64'd0);
        chk("arst_last", 64'(out_last), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_dropped", 64'(dropped), 64'd0);
        chk("arst_seq", 64'(seq), 64'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        sw_trigger = 1'b1;
        cyc();
        sw_trigger = 1'b0;
        chk("post_rst_hdr", 64'(out_data), 64'h0000_0000_A501_0006);
        chk("post_rst_seq", 64'(seq), 64'h1);
        drain();

        // Randomised mix of intervals, triggers, enable and backpressure.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) interval = $urandom_range(0, 12);
            enable     = ($urandom_range(0, 19) != 0);
            sw_trigger = ($urandom_range(0, 9) == 0);
            out_ready  = ($urandom_range(0, 9) < 7);
            cyc();
        end
        enable = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/telemetry_sampler.md
# telemetry_sampler

Controller that sequences sampling of the core telemetry counters (`mcycle`, `minstret`, `stall_cycles`). On a periodic timer tick or a software trigger it atomically snapshots all three counters and serializes them as a 7-word, 32-bit packet on a valid/ready stream toward the trace/MMIO debug path. It sits beside the counter block in the core and is configured from debug CSRs.

## Interface
- `WIDTH`, 64, counter width (32..64), zero-extended to 64 in packets
- `TIMER_W`, 32, width of interval timer/config

- `clk`  in  1  core clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `enable`  in  1  sampler enable (CSR)
- `interval`  in  TIMER_W  sample period in cycles; 0 = periodic sampling off
- `sw_trigger`  in  1  one-cycle manual sample request
- `mcycle`, `minstret`, `stall_cycles`  in  WIDTH each  live counter values
- `out_valid`  out  1  packet word valid
- `out_ready`  in  1  sink accepts word
- `out_data`  out  32  packet word
- `out_last`  out  1  high on final word (index 6)
- `busy`  out  1  packet in flight (state EMIT)
- `dropped`  out  16  requests lost, saturating
- `seq`  out  8  sequence number of the most recent captured packet

## Operation
- Request (`req`) = `enable & (tick | sw_trigger)`; tick and trigger in the same cycle = one request.
- Timer: `cnt` counts while `enable & interval!=0`; tick when `cnt >= interval-1`, then `cnt<=0`. `>=` covers interval shrinking below `cnt`. `enable` low or `interval==0`: `cnt` held at 0, no ticks.
- FSM states IDLE, EMIT.
  - IDLE: `req` → capture snapshot of all three inputs on that edge, `seq<=seq+1` (wraps 255→0), `idx<=0`, go EMIT.
  - EMIT: `out_valid=1`. Handshake (`out_valid&out_ready`) advances `idx`. Handshake at `idx==6`: if `pending` or `req` in that cycle → recapture, `seq++`, `idx<=0`, clear `pending`, stay in EMIT (no bubble); else go IDLE.
- `req` in EMIT (excluding final-handshake cycle): `pending` clear → set `pending`; `pending` set → `dropped++` (saturates at 0xFFFF).
- Pending requests sample counter values at service time, not at request time.
- Packet words by idx: 0 header `{8'hA5, seq, 16'd6}`; 1/2 `mcycle` lo/hi; 3/4 `minstret` lo/hi; 5/6 `stall_cycles` lo/hi.
- `enable` deasserted mid-packet: current packet and any `pending` request complete. The timer clears and no new requests are accepted.
- Reset values: `out_valid=0`, `out_data=0`, `out_last=0`, `busy=0`, `dropped=0`, `seq=0`, `pending=0`, `cnt=0`, snapshot regs 0, state IDLE. Reset mid-packet aborts the packet immediately.

## Timing
- `req` sampled at edge N → snapshot holds counter values present in cycle N, `out_valid=1` from cycle N+1.
- `out_data` and `out_last` are registered and stay stable while `out_valid & !out_ready`. No combinational path from `out_ready` to `out_data`.
- With `out_ready` held high, a packet occupies 7 cycles. A back-to-back packet starts the next cycle.
- With interval = I, ticks occur every I cycles. The first tick comes I cycles after `enable` rises.

## Structure
- `telemetry_pkg`: `HDR_MAGIC=8'hA5`, `PKT_WORDS=7`, state enum `tsamp_state_e {IDLE, EMIT}`, word-index constants.
- Sub-module `telemetry_interval_timer` (enable, interval → tick). Top level holds the FSM, snapshot regs and word mux.

## Test plan
- interval=10, enable=1, `out_ready`=1, counters driven as free-running values → a packet every 10 cycles. Headers `A5_01_0006`, `A5_02_0006`…; words 1/2 equal the `mcycle` value from the request cycle.
- interval=0, `sw_trigger` pulse with `minstret`=0x1_0000_0002 → words 3/4 = 0x00000002, 0x00000001. `out_last` is high only on word 6.
- `out_ready` low for 20 cycles mid-packet with `sw_trigger` pulsed 3 times → one pending request and `dropped`=2. `out_data` stays stable throughout. Two packets are emitted back-to-back after ready returns.
- `sw_trigger` asserted in the same cycle as the final handshake → next header follows with no idle cycle, and `seq` increments by 1.
- 256 packets emitted → `seq` wraps to 0x00. Forcing `dropped` past 0xFFFF → it saturates at 0xFFFF.
- `rst_n` asserted during word 3 → all outputs are 0 asynchronously. After release, the next trigger produces a packet with `seq`=1.
